// File: rtl/mcm_pipe_n.sv
// rtl/mcm_pipe_n.sv - two-stage valid/ready multi-lane multiple-constant multiplier with output saturation
module mcm_pipe_n #(
    parameter int IN_W   = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16,
    parameter int LANES  = 4,
    parameter int NSETS  = 4,
    parameter logic [NSETS*2*COEF_W-1:0] COEFS = 64'h0301_05FF_06FE_07FD,
    localparam int SEL_W = (NSETS > 1) ? $clog2(NSETS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_x,
    input  logic [SEL_W-1:0]       in_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_y0,
    output logic [LANES*OUT_W-1:0] out_y1,
    output logic [2*LANES-1:0]     out_sat,
    output logic                   out_sel_err
);

    localparam int PW   = IN_W + COEF_W + 1;
    localparam int HALF = COEF_W / 2;
    localparam int EW   = (PW > OUT_W) ? PW : OUT_W;
    localparam logic signed [EW-1:0] MAXV = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EW-1:0] MINV = ~MAXV;

    function automatic logic [COEF_W:0] coef_mag(input int s, input int k);
        logic signed [COEF_W:0] c;
        c = {COEFS[(2*s+k+1)*COEF_W-1], COEFS[(2*s+k)*COEF_W +: COEF_W]};
        return c[COEF_W] ? -c : c;
    endfunction

    function automatic logic coef_neg(input int s, input int k);
        return COEFS[(2*s+k+1)*COEF_W-1];
    endfunction

    logic                   w_s2_en;
    logic                   w_accept;
    logic [PW-1:0]          w_lo [LANES][2];
    logic [PW-1:0]          w_hi [LANES][2];
    logic [1:0]             w_neg;
    logic                   w_err;
    logic [LANES*OUT_W-1:0] w_y0;
    logic [LANES*OUT_W-1:0] w_y1;
    logic [2*LANES-1:0]     w_sat;

    logic                   r1_valid;
    logic [PW-1:0]          r1_lo [LANES][2];
    logic [PW-1:0]          r1_hi [LANES][2];
    logic [1:0]             r1_neg;
    logic                   r1_err;
    logic                   r2_valid;
    logic [LANES*OUT_W-1:0] r2_y0;
    logic [LANES*OUT_W-1:0] r2_y1;
    logic [2*LANES-1:0]     r2_sat;
    logic                   r2_err;

    assign w_s2_en  = !r2_valid || out_ready;
    assign in_ready = !r1_valid || w_s2_en;
    assign w_accept = in_valid && in_ready;

    // Stage 1: magnitude of each constant split into low/high bit groups, each a fixed shift-add tree.
    always_comb begin
        logic [COEF_W:0] m;
        m     = '0;
        w_neg = '0;
        w_err = (32'(in_sel) >= 32'(NSETS));
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < 2; k++) begin
                w_lo[i][k] = '0;
                w_hi[i][k] = '0;
            end
        end
        for (int s = 0; s < NSETS; s++) begin
            if (32'(in_sel) == 32'(s)) begin
                for (int k = 0; k < 2; k++) begin
                    w_neg[k] = coef_neg(s, k);
                    m        = coef_mag(s, k);
                    for (int i = 0; i < LANES; i++) begin
                        for (int b = 0; b <= COEF_W; b++) begin
                            if (m[b]) begin
                                if (b < HALF)
                                    w_lo[i][k] = w_lo[i][k] + (PW'(in_x[i*IN_W +: IN_W]) << b);
                                else
                                    w_hi[i][k] = w_hi[i][k] + (PW'(in_x[i*IN_W +: IN_W]) << b);
                            end
                        end
                    end
                end
            end
        end
    end

    // Stage 2: final sum, sign applied, clamped to the OUT_W signed range.
    always_comb begin
        logic [PW-1:0]        sum;
        logic signed [PW-1:0] prod;
        logic signed [EW-1:0] pe;
        logic [OUT_W-1:0]     y;
        sum   = '0;
        prod  = '0;
        pe    = '0;
        y     = '0;
        w_y0  = '0;
        w_y1  = '0;
        w_sat = '0;
        for (int i = 0; i < LANES; i++) begin
            for (int k = 0; k < 2; k++) begin
                sum  = r1_lo[i][k] + r1_hi[i][k];
                prod = r1_neg[k] ? -$signed(sum) : $signed(sum);
                pe   = EW'(prod);
                if (pe > MAXV) begin
                    y            = MAXV[OUT_W-1:0];
                    w_sat[2*i+k] = 1'b1;
                end else if (pe < MINV) begin
                    y            = MINV[OUT_W-1:0];
                    w_sat[2*i+k] = 1'b1;
                end else begin
                    y = pe[OUT_W-1:0];
                end
                if (k == 0) w_y0[i*OUT_W +: OUT_W] = y;
                else        w_y1[i*OUT_W +: OUT_W] = y;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r1_valid <= 1'b0;
            r1_neg   <= '0;
            r1_err   <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                for (int k = 0; k < 2; k++) begin
                    r1_lo[i][k] <= '0;
                    r1_hi[i][k] <= '0;
                end
            end
            r2_valid <= 1'b0;
            r2_y0    <= '0;
            r2_y1    <= '0;
            r2_sat   <= '0;
            r2_err   <= 1'b0;
        end else if (flush) begin
            r1_valid <= 1'b0;
            r2_valid <= 1'b0;
        end else begin
            if (w_s2_en) begin
                r2_valid <= r1_valid;
                if (r1_valid) begin
                    r2_y0  <= w_y0;
                    r2_y1  <= w_y1;
                    r2_sat <= w_sat;
                    r2_err <= r1_err;
                end
            end
            if (w_accept) begin
                r1_valid <= 1'b1;
                r1_lo    <= w_lo;
                r1_hi    <= w_hi;
                r1_neg   <= w_neg;
                r1_err   <= w_err;
            end else if (w_s2_en) begin
                r1_valid <= 1'b0;
            end
        end
    end

    assign out_valid   = r2_valid;
    assign out_y0      = r2_y0;
    assign out_y1      = r2_y1;
    assign out_sat     = r2_sat;
    assign out_sel_err = r2_err;

endmodule

// File: tb/tb_mcm_pipe_n.sv
// tb/tb_mcm_pipe_n.sv - table vectors plus scoreboard for mcm_pipe_n (default, OUT_W=10, NSETS=3 instances)
module tb_mcm_pipe_n;

    typedef struct packed {
        logic [63:0] y0;
        logic [63:0] y1;
        logic [7:0]  sat;
        logic        err;
    } res_t;

    typedef struct {
        res_t a;
        res_t b;
        res_t c;
    } sb_t;

    typedef struct {
        logic [31:0] x;
        logic [1:0]  sel;
        logic [63:0] y0;
        logic [63:0] y1;
    } vec_t;

    localparam int C0_T[4] = '{-3, -2, -1, 1};
    localparam int C1_T[4] = '{7, 6, 5, 3};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_x;
    logic [1:0]  in_sel;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_sel_err;
    logic [63:0] a_out_y0, a_out_y1;
    logic [7:0]  a_out_sat;
    logic        b_in_ready, b_out_valid, b_out_sel_err;
    logic [39:0] b_out_y0, b_out_y1;
    logic [7:0]  b_out_sat;
    logic        c_in_ready, c_out_valid, c_out_sel_err;
    logic [63:0] c_out_y0, c_out_y1;
    logic [7:0]  c_out_sat;

    always #5 clk = ~clk;

    mcm_pipe_n dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_x(in_x), .in_sel(in_sel), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_y0(a_out_y0), .out_y1(a_out_y1), .out_sat(a_out_sat), .out_sel_err(a_out_sel_err)
    );

    mcm_pipe_n #(.OUT_W(10)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_x(in_x), .in_sel(in_sel), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_y0(b_out_y0), .out_y1(b_out_y1), .out_sat(b_out_sat), .out_sel_err(b_out_sel_err)
    );

    mcm_pipe_n #(.NSETS(3), .COEFS(48'h05FF_06FE_07FD)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
        .in_x(in_x), .in_sel(in_sel), .out_valid(c_out_valid), .out_ready(out_ready),
        .out_y0(c_out_y0), .out_y1(c_out_y1), .out_sat(c_out_sat), .out_sel_err(c_out_sel_err)
    );

    int   n_total = 0;
    int   n_pass  = 0;
    int   n_acc   = 0;
    int   n_pop   = 0;
    sb_t  sb[$];
    res_t drv_exp;
    vec_t vt[5];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    endtask

    function automatic res_t model(input logic [31:0] xp, input logic [1:0] sel, input int ow, input int nsets);
        res_t   r;
        longint p, mx, v;
        int     c;
        logic [63:0] m;
        bit     s;
        r  = '0;
        mx = (longint'(1) <<< (ow - 1)) - 1;
        m  = (64'd1 << ow) - 1;
        if (int'(sel) >= nsets) begin
            r.err = 1'b1;
            return r;
        end
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 2; k++) begin
                c = (k == 0) ? C0_T[sel] : C1_T[sel];
                p = longint'({56'd0, xp[i*8 +: 8]}) * longint'(c);
                s = 1'b1;
                if (p > mx) v = mx;
                else if (p < -mx - 1) v = -mx - 1;
                else begin v = p; s = 1'b0; end
                if (k == 0) r.y0 = r.y0 | ((64'(v) & m) << (i * ow));
                else        r.y1 = r.y1 | ((64'(v) & m) << (i * ow));
                r.sat[2*i+k] = s;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] px(input int x0, input int x1, input int x2, input int x3);
        return {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    endfunction

    function automatic logic [63:0] pk(input int a0, input int a1, input int a2, input int a3);
        return {16'(a3), 16'(a2), 16'(a1), 16'(a0)};
    endfunction

    task automatic set_beat(input logic [31:0] x, input logic [1:0] sel);
        in_x    = x;
        in_sel  = sel;
        drv_exp = model(x, sel, 16, 4);
    endtask

    task automatic apply_vec(input int idx);
        in_x       = vt[idx].x;
        in_sel     = vt[idx].sel;
        drv_exp    = '0;
        drv_exp.y0 = vt[idx].y0;
        drv_exp.y1 = vt[idx].y1;
    endtask

    task automatic latency_checks(input string tag);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_valid_t0"}, 64'(a_out_valid), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_valid_t1"}, 64'(a_out_valid), 64'd1);
        @(posedge clk); #1;
        chk({tag, "_valid_t2"}, 64'(a_out_valid), 64'd0);
    endtask

    task automatic drain(input string tag);
        for (int c = 0; c < 20 && sb.size() != 0; c++) begin
            @(posedge clk); #1;
        end
        chk({tag, "_drain"}, 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (rst_n) begin
            if (a_out_valid && out_ready) begin
                n_pop++;
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_output: got a beat with y0=0x%0h, required none", a_out_y0);
                end else begin
                    e = sb.pop_front();
                    chk("a_y0", a_out_y0, e.a.y0);
                    chk("a_y1", a_out_y1, e.a.y1);
                    chk("a_sat", 64'(a_out_sat), 64'(e.a.sat));
                    chk("a_err", 64'(a_out_sel_err), 64'(e.a.err));
                    chk("b_valid", 64'(b_out_valid), 64'd1);
                    chk("b_y0", 64'(b_out_y0), e.b.y0);
                    chk("b_y1", 64'(b_out_y1), e.b.y1);
                    chk("b_sat", 64'(b_out_sat), 64'(e.b.sat));
                    chk("c_y0", c_out_y0, e.c.y0);
                    chk("c_y1", c_out_y1, e.c.y1);
                    chk("c_err", 64'(c_out_sel_err), 64'(e.c.err));
                end
            end
            if (flush) begin
                sb.delete();
            end else if (in_valid && a_in_ready) begin
                n_acc++;
                e.a = drv_exp;
                e.b = model(in_x, in_sel, 10, 4);
                e.c = model(in_x, in_sel, 16, 3);
                sb.push_back(e);
            end
        end
    end

    initial begin
        int          a0, p0, n_stall, n_gap;
        logic [63:0] s_y0, s_y1;
        logic [7:0]  s_sat;

        vt[0] = '{px(128, 0, 1, 255),   2'd0, pk(-384, 0, -3, -765),     pk(896, 0, 7, 1785)};
        vt[1] = '{px(255, 64, 10, 200), 2'd0, pk(-765, -192, -30, -600), pk(1785, 448, 70, 1400)};
        vt[2] = '{px(255, 255, 255, 255), 2'd3, pk(255, 255, 255, 255),  pk(765, 765, 765, 765)};
        vt[3] = '{px(10, 20, 30, 40),   2'd1, pk(-20, -40, -60, -80),    pk(60, 120, 180, 240)};
        vt[4] = '{px(0, 255, 7, 100),   2'd2, pk(0, -255, -7, -100),     pk(0, 1275, 35, 500)};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_x = '0; in_sel = '0; out_ready = 1'b1;
        drv_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_y0", a_out_y0, 64'd0);
        chk("rst_y1", a_out_y1, 64'd0);
        chk("rst_sat", 64'(a_out_sat), 64'd0);
        chk("rst_err", 64'(a_out_sel_err), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(a_in_ready), 64'd1);

        apply_vec(0);
        in_valid = 1'b1;
        latency_checks("lat_first");
        drain("lat_first");

        for (int v = 0; v < 5; v++) begin
            apply_vec(v);
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        drain("table");

        p0 = n_pop; n_stall = 0; n_gap = 0;
        for (int i = 0; i < 8; i++) begin
            set_beat(px(i*20, i*20+1, i*20+2, i*20+3), 2'(i % 4));
            in_valid = 1'b1;
            if (!a_in_ready) n_stall++;
            @(posedge clk); #1;
            if (i >= 1 && !a_out_valid) n_gap++;
        end
        in_valid = 1'b0;
        chk("stream_in_ready", 64'(n_stall), 64'd0);
        chk("stream_no_gap", 64'(n_gap), 64'd0);
        drain("stream");
        chk("stream_count", 64'(n_pop - p0), 64'd8);

        out_ready = 1'b0; a0 = n_acc; p0 = n_pop;
        s_y0 = '0; s_y1 = '0; s_sat = '0;
        for (int c = 0; c < 5; c++) begin
            set_beat(px(200 + c, 100 + c, 3*c, 250 - c), 2'(c % 4));
            in_valid = 1'b1;
            @(posedge clk); #1;
            if (c == 1) begin
                s_y0 = a_out_y0; s_y1 = a_out_y1; s_sat = a_out_sat;
            end else if (c > 1) begin
                chk("stall_valid", 64'(a_out_valid), 64'd1);
                chk("stall_y0", a_out_y0, s_y0);
                chk("stall_y1", a_out_y1, s_y1);
                chk("stall_sat", 64'(a_out_sat), 64'(s_sat));
            end
        end
        chk("bp_accepts", 64'(n_acc - a0), 64'd2);
        chk("bp_in_ready", 64'(a_in_ready), 64'd0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain("bp");
        chk("bp_count", 64'(n_pop - p0), 64'd2);

        out_ready = 1'b0; p0 = n_pop;
        set_beat(px(1, 2, 3, 4), 2'd0);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_beat(px(5, 6, 7, 8), 2'd1);
        @(posedge clk); #1;
        set_beat(px(9, 10, 11, 12), 2'd2);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_valid", 64'(a_out_valid), 64'd0);
        chk("flush_in_ready", 64'(a_in_ready), 64'd1);
        set_beat(px(13, 14, 15, 16), 2'd3);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("flush_no_output", 64'(n_pop - p0), 64'd0);

        out_ready = 1'b0;
        set_beat(px(50, 60, 70, 80), 2'd1);
        in_valid = 1'b1;
        @(posedge clk); #1;
        set_beat(px(90, 91, 92, 93), 2'd2);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_reset_valid", 64'(a_out_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("async_rst_valid", 64'(a_out_valid), 64'd0);
        chk("async_rst_y0", a_out_y0, 64'd0);
        chk("async_rst_y1", a_out_y1, 64'd0);
        chk("async_rst_sat", 64'(a_out_sat), 64'd0);
        chk("async_rst_in_ready", 64'(a_in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        set_beat(px(255, 64, 128, 1), 2'd0);
        in_valid = 1'b1;
        latency_checks("lat_post_reset");
        drain("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mcm_pipe_n.md
# mcm_pipe_n

Pipelined, multi-lane multiple-constant multiplier for the intra angular sample datapath. Each lane multiplies an unsigned reference sample by two signed constants. The constant pair comes from a parameter table and is selected per beat. Beats move through a two-stage valid/ready pipeline with output saturation. The block sits between the reference-sample buffer and the averaging/filter adder trees, and replaces the fixed, combinational, single-sample constant multipliers.

## Interface
- `IN_W`, 8: unsigned sample width.
- `COEF_W`, 8: signed coefficient width.
- `OUT_W`, 16: signed product width per output, saturated.
- `LANES`, 4: samples processed per beat.
- `NSETS`, 4: number of coefficient pairs; `SEL_W = max(1, clog2(NSETS))`.
- `COEFS`, {(-3,7), (-2,6), (-1,5), (1,3)}: packed `NSETS*2*COEF_W` bits. Set s occupies bits `[(2s+1)*COEF_W-1 : 2s*COEF_W]` = C0 and the next `COEF_W` bits = C1.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous pipeline clear.
- `in_valid` in 1: input beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `in_x` in `LANES*IN_W`: lane i at `[(i+1)*IN_W-1 : i*IN_W]`, unsigned.
- `in_sel` in `SEL_W`: coefficient set for this beat.
- `out_valid` out 1: output beat valid.
- `out_ready` in 1: downstream accepts.
- `out_y0` out `LANES*OUT_W`: per-lane X*C0, signed.
- `out_y1` out `LANES*OUT_W`: per-lane X*C1, signed.
- `out_sat` out `2*LANES`: bit 2i = lane i y0 saturated, bit 2i+1 = lane i y1 saturated.
- `out_sel_err` out 1: the beat's `in_sel` was >= `NSETS`.

## Operation
- Exact product: zero-extend X to `IN_W+1` bits signed, then multiply by C at `IN_W+COEF_W+1` bits. No intermediate truncation.
- Implementation form:
  - Constants are elaboration-time, so the products must be built as shift-add/subtract networks. There are no generic multipliers on `in_x`.
  - Stage 1 registers the shifted partial terms, or the first-level sums.
  - Stage 2 registers the final sums, after saturation.
- Saturation:
  - If the exact product exceeds the `OUT_W` signed range, output the nearest bound, `2^(OUT_W-1)-1` or `-2^(OUT_W-1)`, and set the matching `out_sat` bit.
  - Otherwise output the sign-extended product and clear the bit.
- `in_sel` travels with its beat. Changing `in_sel` never affects beats already accepted.
- `in_sel >= NSETS`, only possible when `NSETS` is not a power of 2: all products are 0, `out_sat` = 0 and `out_sel_err` = 1 for that beat.
- Pipeline control: stage registers S1 and S2, each with a valid bit.
  - S2 loads when S2 is empty or `out_ready` = 1.
  - S1 advances into S2 under that same condition.
  - `in_ready = !S1.valid | (!S2.valid | out_ready)`, i.e. bubbles collapse.
  - A beat is accepted on a rising edge with `in_valid & in_ready`.
- Outputs are driven directly from S2: `out_valid = S2.valid`. Data, `out_sat` and `out_sel_err` are held stable while `out_valid & !out_ready`.
- `flush` = 1 at a rising edge clears both valid bits. Any beat offered in that cycle is discarded, even if `in_ready` was 1, so flush wins. Data registers may keep stale values, but only while the corresponding valid bit is 0.

## Timing
- Reset (`rst_n` low, asynchronous):
  - S1/S2 valid = 0.
  - `out_valid` = 0, `out_y0` = `out_y1` = 0, `out_sat` = 0, `out_sel_err` = 0.
  - `in_ready` = 1 from the first cycle after deassertion.
  - Reset mid-stream drops all in-flight beats; nothing is replayed.
- Latency: a beat accepted at edge t appears on the outputs after edge t+1, with `out_valid` high in the cycle following t+1. Latency is 2 cycles with no backpressure.
- Throughput: 1 beat per cycle with `out_ready` held high.
- Backpressure:
  - With `out_ready` = 0 and both stages full, `in_ready` = 0 combinationally in that cycle.
  - With `out_ready` = 0 and S1 empty, the block still accepts exactly one beat into S1.
- Simultaneous events: with S2 full, the S2 beat leaving (`out_ready` = 1) and S1 advancing happen on the same edge. No bubble is inserted.
- `out_ready` may toggle while `out_valid` = 0 without effect.
- `in_ready` depends combinationally on `out_ready`. `out_*` are registered only.

## Test plan
- Defaults, `in_x` = {255, 1, 0, 128}, `in_sel` = 0, one beat, `out_ready` = 1 → two cycles later `out_valid` = 1 for one cycle.
  - `out_y0` = {-765, -3, 0, -384}.
  - `out_y1` = {1785, 7, 0, 896}.
  - `out_sat` = 0.
- `OUT_W` = 10, `in_x` lane0 = 255, `in_sel` = 0 → y0 = -512 and y1 = 511, with `out_sat[1:0]` = 2'b11. Lane with x = 64 → y0 = -192 and y1 = 448, no sat.
- Stream 8 beats with x incrementing and `in_sel` cycling 0..3, `out_ready` = 1 → 8 consecutive valid outputs, each matching its own set. `in_ready` stays 1 throughout.
- Backpressure:
  - Hold `out_ready` = 0 for 5 cycles while `in_valid` = 1 → exactly 2 beats accepted, then `in_ready` = 0.
  - The output is held stable for the whole stall.
  - After release, beats emerge in order with no loss or duplication.
- `NSETS` = 3, `in_sel` = 3, x = 200 → y0 = y1 = 0, `out_sel_err` = 1. The next beat with `in_sel` = 1, x = 10 → y0 = -20, y1 = 60, `out_sel_err` = 0.
- Flush and reset:
  - With two beats in flight, assert `flush` together with a new `in_valid` → no outputs ever emerge for any of those 3 beats.
  - Separately, pull `rst_n` low mid-stall → all outputs are 0 immediately (asynchronous), and the first post-reset beat has normal 2-cycle latency.
